// File: rtl/filter_sink.sv
// filter_sink
//   Output stage for the filter result stream. Each incoming sample is
//   parity-checked. Good samples go into a small circular FIFO that is
//   drained over a valid/ready handshake. Bad samples are counted and
//   discarded. Good samples that arrive while the FIFO is full, with no
//   pop in the same cycle, are dropped and flagged. The upstream filter
//   is never stalled.
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   x_data     sample from the filter
//   x_valid    sample present this cycle
//   x_parity   even-parity bit for x_data
//   y_ready    downstream takes the head entry this cycle
//   y_data     head-of-FIFO sample, 0 when empty
//   y_valid    FIFO non-empty
//   y_parity   regenerated even parity of y_data
//   level      occupancy, 0..DEPTH
//   err_count  saturating parity-error count
//   overflow   sticky drop flag, cleared only by reset
module filter_sink #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8,
  parameter int DATA_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          x_data,
  input  logic                       x_valid,
  input  logic                       x_parity,
  input  logic                       y_ready,
  output logic [DATA_W-1:0]          y_data,
  output logic                       y_valid,
  output logic                       y_parity,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_WIDTH-1:0]       err_count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_nxt;

  logic par_bad;
  logic good;
  logic bad;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Input qualification: parity check and push/pop/drop decisions.
  always_comb begin
    par_bad = (^x_data) ^ x_parity;
    good    = x_valid & ~par_bad;
    bad     = x_valid &  par_bad;
    full    = (level == LVL_W'(DEPTH));
    pop     = y_valid & y_ready;
    // A pop in the same edge frees the slot, so a full FIFO still accepts.
    push    = good & (~full | pop);
    drop    = good & full & ~pop;

    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Storage: data only, never reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= x_data;
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      if (bad)  err_count <= sat_inc(err_count);
      if (drop) overflow  <= 1'b1;
    end
  end

  // Output view, derived only from registered state.
  always_comb begin
    y_valid  = (level != '0);
    y_data   = y_valid ? mem[rd_ptr] : '0;
    y_parity = ^y_data;
  end

endmodule

// File: tb/tb_filter_sink.sv
module tb_filter_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x_data;
  logic        x_valid;
  logic        x_parity;
  logic        y_ready;
  logic [15:0] y_data;
  logic        y_valid;
  logic        y_parity;
  logic [2:0]  level;
  logic [7:0]  err_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  filter_sink #(.DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_parity(x_parity),
    .y_ready(y_ready),
    .y_data(y_data), .y_valid(y_valid), .y_parity(y_parity),
    .level(level), .err_count(err_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a good sample for one cycle and, if it should be accepted,
  // record it as an expected output.
  task automatic send_good(input logic [15:0] d, input bit accepted);
    x_data   = d;
    x_parity = ^d;
    x_valid  = 1'b1;
    if (accepted) exp_q.push_back(d);
    tick();
    x_valid  = 1'b0;
  endtask

  task automatic send_bad(input logic [15:0] d);
    x_data   = d;
    x_parity = ~(^d);
    x_valid  = 1'b1;
    tick();
    x_valid  = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " y_data"},    int'(y_data),    0);
    chk({tag, " y_valid"},   int'(y_valid),   0);
    chk({tag, " y_parity"},  int'(y_parity),  0);
    chk({tag, " level"},     int'(level),     0);
    chk({tag, " err_count"}, int'(err_count), 0);
    chk({tag, " overflow"},  int'(overflow),  0);
  endtask

  // Monitor: every handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h with no sample expected", y_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("out_data", int'(y_data), int'(e));
        chk("out_parity", int'(y_parity), int'(^e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with an input sample present: it must be ignored.
    reset = 1'b1; x_valid = 1'b1; x_data = 16'h0003; x_parity = 1'b0; y_ready = 1'b0;
    tick();
    tick();
    chk_reset_state("reset");
    reset = 1'b0; x_valid = 1'b0;

    // Single good sample, visible one cycle later, then popped.
    send_good(16'h000C, 1'b1);
    chk("single y_valid",  int'(y_valid),  1);
    chk("single y_data",   int'(y_data),   16'h000C);
    chk("single y_parity", int'(y_parity), 0);
    chk("single level",    int'(level),    1);
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    chk("single drained y_valid", int'(y_valid), 0);
    chk("single drained y_data",  int'(y_data),  0);

    // Parity error counting and saturation.
    x_data = 16'h0001; x_parity = 1'b0; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    chk("perr err_count", int'(err_count), 1);
    chk("perr level",     int'(level),     0);
    chk("perr y_valid",   int'(y_valid),   0);
    for (int i = 0; i < 253; i++) send_bad(16'(i));
    chk("perr 254", int'(err_count), 8'hFE);
    send_bad(16'h1234);
    chk("perr 255", int'(err_count), 8'hFF);
    for (int i = 0; i < 10; i++) send_bad(16'h00F0 + 16'(i));
    chk("perr saturated", int'(err_count), 8'hFF);

    // Fill and overflow.
    reset = 1'b1; tick(); reset = 1'b0;
    y_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_good(16'(i), 1'b1);
    chk("fill level4", int'(level), 4);
    chk("fill no overflow yet", int'(overflow), 0);
    chk("fill parity bit 3", int'(^16'h0003), 0);
    send_good(16'h0005, 1'b0);
    chk("overflow level", int'(level), 4);
    chk("overflow set", int'(overflow), 1);
    y_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drain y_valid", int'(y_valid), 0);
    chk("drain level",   int'(level),   0);
    chk("overflow sticky", int'(overflow), 1);
    y_ready = 1'b0;

    // Full with simultaneous push and pop, then streaming with wrap.
    reset = 1'b1; tick(); reset = 1'b0;
    chk("pre-full overflow", int'(overflow), 0);
    for (int i = 0; i < 4; i++) send_good(16'h0010 + 16'(i), 1'b1);
    chk("full level", int'(level), 4);
    y_ready = 1'b1;
    send_good(16'h0014, 1'b1);
    chk("pushpop level", int'(level), 4);
    chk("pushpop overflow", int'(overflow), 0);
    chk("pushpop head", int'(y_data), 16'h0011);
    for (int i = 0; i < 10; i++) send_good(16'h0A20 + 16'(i * 3), 1'b1);
    chk("stream level", int'(level), 4);
    chk("stream overflow", int'(overflow), 0);
    for (int i = 0; i < 4; i++) tick();
    chk("stream drained level", int'(level), 0);
    chk("stream drained valid", int'(y_valid), 0);
    y_ready = 1'b0;

    // Reset mid-operation.
    for (int i = 0; i < 4; i++) send_good(16'h0030 + 16'(i), 1'b1);
    send_good(16'h0034, 1'b0);
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    send_bad(16'h0007);
    send_bad(16'h0100);
    chk("mid level",    int'(level),     3);
    chk("mid err",      int'(err_count), 2);
    chk("mid overflow", int'(overflow),  1);
    reset = 1'b1; x_valid = 1'b1; x_data = 16'h0055; x_parity = 1'b0;
    tick();
    reset = 1'b0; x_valid = 1'b0;
    exp_q.delete();
    chk_reset_state("midreset");
    send_good(16'h0077, 1'b1);
    chk("post-reset level",  int'(level),  1);
    chk("post-reset y_data", int'(y_data), 16'h0077);
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    chk("post-reset drained", int'(y_valid), 0);
    chk("scoreboard empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
